// File: rtl/dp_result_checker_if.sv
// Handshake/result bus between a datapath testbench and dp_result_checker.
// Suffixes are from the checker's point of view; the bench drives through the master modport.
interface dp_result_checker_if #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned CNTW  = 16
);
    logic             start_i;
    logic             launch_i;
    logic             last_i;
    logic [DATAW-1:0] exp_z_i;
    logic [DATAW-1:0] exp_x_i;
    logic [DATAW-1:0] dut_z_i;
    logic [DATAW-1:0] dut_x_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [CNTW-1:0]  chk_cnt_o;
    logic [CNTW-1:0]  err_cnt_o;
    logic [CNTW-1:0]  fail_idx_o;
    logic [DATAW-1:0] fail_z_o;
    logic [DATAW-1:0] fail_x_o;

    modport slave (
        input  start_i, launch_i, last_i, exp_z_i, exp_x_i, dut_z_i, dut_x_i,
        output busy_o, done_o, pass_o, chk_cnt_o, err_cnt_o, fail_idx_o, fail_z_o, fail_x_o
    );

    modport master (
        output start_i, launch_i, last_i, exp_z_i, exp_x_i, dut_z_i, dut_x_i,
        input  busy_o, done_o, pass_o, chk_cnt_o, err_cnt_o, fail_idx_o, fail_z_o, fail_x_o
    );
endinterface

// File: rtl/dp_result_checker.sv
// Delays launched expectations by the DUT latency, compares them with DUT outputs,
// counts checks/errors, captures the first failure and reports done/pass.
module dp_result_checker #(
    parameter int unsigned DATAW   = 32,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNTW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dp_result_checker_if.slave bus
);
    localparam int unsigned LAST = LATENCY - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            pass_q, pass_d;
    logic                            first_q, first_d;
    logic [CNTW-1:0]                 chk_q, chk_d;
    logic [CNTW-1:0]                 err_q, err_d;
    logic [CNTW-1:0]                 fidx_q, fidx_d;
    logic [DATAW-1:0]                fz_q, fz_d;
    logic [DATAW-1:0]                fx_q, fx_d;

    logic [LATENCY-1:0]              vld_q;
    logic [LATENCY-1:0]              lst_q;
    logic [LATENCY-1:0][DATAW-1:0]   ez_q;
    logic [LATENCY-1:0][DATAW-1:0]   ex_q;

    logic                            enter_run_c;
    logic                            mature_c;
    logic                            mismatch_c;

    // Oldest delay-line entry lines up with the DUT outputs sampled this edge
    always_comb begin
        enter_run_c = bus.start_i && (state_q != S_RUN);
        mature_c    = vld_q[LAST] && (state_q == S_RUN);
        mismatch_c  = (ez_q[LAST] != bus.dut_z_i) || (ex_q[LAST] != bus.dut_x_i);
    end

    // Next-state, counters and first-failure capture
    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fz_d    = fz_q;
        fx_d    = fx_q;
        first_d = first_q;

        case (state_q)
            S_IDLE, S_DONE: if (bus.start_i) state_d = S_RUN;
            S_RUN:          if (mature_c && lst_q[LAST]) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase

        if (enter_run_c) begin
            chk_d   = '0;
            err_d   = '0;
            fidx_d  = '0;
            fz_d    = '0;
            fx_d    = '0;
            first_d = 1'b0;
        end else if (mature_c) begin
            chk_d = chk_q + CNTW'(1);
            if (mismatch_c) begin
                if (err_q != {CNTW{1'b1}}) err_d = err_q + CNTW'(1);
                if (!first_q) begin
                    fidx_d  = chk_q;
                    fz_d    = bus.dut_z_i;
                    fx_d    = bus.dut_x_i;
                    first_d = 1'b1;
                end
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        pass_d = (state_d == S_DONE) && (err_d == '0) && (chk_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            first_q <= 1'b0;
            chk_q   <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fz_q    <= '0;
            fx_q    <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
            ez_q    <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            first_q <= first_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fz_q    <= fz_d;
            fx_q    <= fx_d;

            // Expectation pipeline; a new run starts with an empty line
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1] && !enter_run_c;
                lst_q[i] <= lst_q[i-1];
                ez_q[i]  <= ez_q[i-1];
                ex_q[i]  <= ex_q[i-1];
            end
            vld_q[0] <= bus.launch_i && busy_q;
            lst_q[0] <= bus.last_i;
            ez_q[0]  <= bus.exp_z_i;
            ex_q[0]  <= bus.exp_x_i;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.pass_o     = pass_q;
    assign bus.chk_cnt_o  = chk_q;
    assign bus.err_cnt_o  = err_q;
    assign bus.fail_idx_o = fidx_q;
    assign bus.fail_z_o   = fz_q;
    assign bus.fail_x_o   = fx_q;
endmodule
